// File: rtl/sprite_pkg.sv
// Shared constants, attribute types and sheet addressing helper for the sprite fetch pipeline.
package sprite_pkg;

  localparam int         SPR_W      = 32;
  localparam int         SHEET_W    = 256;
  localparam int         COORD_W    = 10;
  localparam logic [4:0] TRANSP_IDX = 5'h00;
  localparam int         ROM_LAT    = 1;
  localparam int         LOC_W      = $clog2(SPR_W);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [5:0]         tile;
    logic               flip;
    logic               en;
  } sprite_attr_t;

  typedef struct packed {
    logic               hit;
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } side_t;

  // Sheet offset of a tile's top-left pixel; tile = {row[2:0], col[2:0]}.
  function automatic logic [15:0] tile_base(input logic [5:0] tile);
    return (16'(tile[5:3]) * 16'(SPR_W * SHEET_W)) + (16'(tile[2:0]) * 16'(SPR_W));
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Per-sprite bounding-box test and sheet address generation for one screen pixel.
module sprite_hit
  import sprite_pkg::*;
(
  input  sprite_attr_t       attr,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               hit,
  output logic [15:0]        addr
);

  logic [COORD_W:0] dx_s;
  logic [COORD_W:0] dy_s;
  logic [LOC_W-1:0] lx_s;
  logic [LOC_W-1:0] ly_s;

  // One extra bit so a pixel left of / above the sprite shows up as negative.
  assign dx_s = {1'b0, draw_x} - {1'b0, attr.x};
  assign dy_s = {1'b0, draw_y} - {1'b0, attr.y};

  assign hit = attr.en
             & ~dx_s[COORD_W] & (dx_s[COORD_W-1:0] < COORD_W'(SPR_W))
             & ~dy_s[COORD_W] & (dy_s[COORD_W-1:0] < COORD_W'(SPR_W));

  assign lx_s = attr.flip ? (LOC_W'(SPR_W - 1) - dx_s[LOC_W-1:0]) : dx_s[LOC_W-1:0];
  assign ly_s = dy_s[LOC_W-1:0];

  assign addr = tile_base(attr.tile) + (16'(ly_s) * 16'(SHEET_W)) + 16'(lx_s);

endmodule

// File: rtl/sprite_fetch.sv
// Sprite ROM address generator and 3-cycle aligned compositor front-end with
// frame-synchronous shadow attributes.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 4
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             frame_start,
  input  logic [NUM_SPR-1:0][COORD_W-1:0]  spr_x,
  input  logic [NUM_SPR-1:0][COORD_W-1:0]  spr_y,
  input  logic [NUM_SPR-1:0][5:0]          spr_tile,
  input  logic [NUM_SPR-1:0]               spr_flip,
  input  logic [NUM_SPR-1:0]               spr_en,
  input  logic [COORD_W-1:0]               DrawX,
  input  logic [COORD_W-1:0]               DrawY,
  input  logic                             pix_valid,
  output logic [15:0]                      rom_addr,
  input  logic [4:0]                       rom_data,
  output logic [4:0]                       pix_idx,
  output logic                             pix_hit,
  output logic                             pix_valid_out,
  output logic [COORD_W-1:0]               DrawX_out,
  output logic [COORD_W-1:0]               DrawY_out
);

  sprite_attr_t [NUM_SPR-1:0]        shadow_r;
  logic [NUM_SPR-1:0]                hit_v_s;
  logic [NUM_SPR-1:0][15:0]          addr_v_s;
  logic                              win_hit_s;
  logic [15:0]                       win_addr_s;
  logic [15:0]                       rom_addr_r;
  side_t [ROM_LAT:0]                 side_r;
  logic                              opaque_s;
  logic [4:0]                        pix_idx_r;
  logic                              pix_hit_r;
  logic                              pix_valid_r;
  logic [COORD_W-1:0]                x_out_r;
  logic [COORD_W-1:0]                y_out_r;

  // Shadow attribute capture, only on frame_start so a frame never tears.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      shadow_r <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_r[i].x    <= spr_x[i];
        shadow_r[i].y    <= spr_y[i];
        shadow_r[i].tile <= spr_tile[i];
        shadow_r[i].flip <= spr_flip[i];
        shadow_r[i].en   <= spr_en[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    sprite_hit u_hit (
      .attr   (shadow_r[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .hit    (hit_v_s[g]),
      .addr   (addr_v_s[g])
    );
  end

  // Priority mux: scanning downward lets the lowest-index hitting sprite win.
  always_comb begin
    win_hit_s  = 1'b0;
    win_addr_s = 16'h0000;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_v_s[i]) begin
        win_hit_s  = 1'b1;
        win_addr_s = addr_v_s[i];
      end else begin
        win_hit_s  = win_hit_s;
        win_addr_s = win_addr_s;
      end
    end
  end

  // Stage 1: ROM address register plus side-band capture.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr_r <= 16'h0000;
      side_r[0]  <= '0;
    end else begin
      rom_addr_r      <= (pix_valid && win_hit_s) ? win_addr_s : rom_addr_r;
      side_r[0].hit   <= pix_valid & win_hit_s;
      side_r[0].valid <= pix_valid;
      side_r[0].x     <= DrawX;
      side_r[0].y     <= DrawY;
    end
  end

  // Side-band delay matching the ROM read latency.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      side_r[ROM_LAT:1] <= '0;
    end else begin
      for (int k = 1; k <= ROM_LAT; k++) begin
        side_r[k] <= side_r[k-1];
      end
    end
  end

  assign opaque_s = side_r[ROM_LAT].hit & (rom_data != TRANSP_IDX);

  // Stage 2: composite output register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_hit_r   <= 1'b0;
      pix_idx_r   <= 5'h00;
      pix_valid_r <= 1'b0;
      x_out_r     <= '0;
      y_out_r     <= '0;
    end else begin
      pix_hit_r   <= opaque_s;
      pix_idx_r   <= opaque_s ? rom_data : 5'h00;
      pix_valid_r <= side_r[ROM_LAT].valid;
      x_out_r     <= side_r[ROM_LAT].x;
      y_out_r     <= side_r[ROM_LAT].y;
    end
  end

  assign rom_addr      = rom_addr_r;
  assign pix_hit       = pix_hit_r;
  assign pix_idx       = pix_idx_r;
  assign pix_valid_out = pix_valid_r;
  assign DrawX_out     = x_out_r;
  assign DrawY_out     = y_out_r;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed self-checking bench for sprite_fetch with a registered ROM model.
module tb_sprite_fetch;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             frame_start;
  logic [3:0][9:0]  spr_x;
  logic [3:0][9:0]  spr_y;
  logic [3:0][5:0]  spr_tile;
  logic [3:0]       spr_flip;
  logic [3:0]       spr_en;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             pix_valid;
  logic [15:0]      rom_addr;
  logic [4:0]       rom_data = 5'h00;
  logic [4:0]       pix_idx;
  logic             pix_hit;
  logic             pix_valid_out;
  logic [9:0]       DrawX_out;
  logic [9:0]       DrawY_out;

  logic [15:0]      hot_addr;
  logic [4:0]       hot_val;
  int               n_tests = 0;
  int               n_fail  = 0;

  sprite_fetch #(.NUM_SPR(4)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_start   (frame_start),
    .spr_x         (spr_x),
    .spr_y         (spr_y),
    .spr_tile      (spr_tile),
    .spr_flip      (spr_flip),
    .spr_en        (spr_en),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .pix_valid     (pix_valid),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .pix_idx       (pix_idx),
    .pix_hit       (pix_hit),
    .pix_valid_out (pix_valid_out),
    .DrawX_out     (DrawX_out),
    .DrawY_out     (DrawY_out)
  );

  always #5 Clk = ~Clk;

  // ROM model: one programmable address, everything else addr[4:0]^0x15.
  function automatic logic [4:0] rom_fn(input logic [15:0] a);
    return (a == hot_addr) ? hot_val : (a[4:0] ^ 5'h15);
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int tile,
                         input logic flip, input logic en);
    spr_x[i]    = 10'(x);
    spr_y[i]    = 10'(y);
    spr_tile[i] = 6'(tile);
    spr_flip[i] = flip;
    spr_en[i]   = en;
  endtask

  task automatic frame();
    pix_valid   = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pixel(input int x, input int y);
    DrawX     = 10'(x);
    DrawY     = 10'(y);
    pix_valid = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    spr_x = '0; spr_y = '0; spr_tile = '0; spr_flip = '0; spr_en = '0;
    DrawX = '0; DrawY = '0;
    hot_addr = 16'hFFFF; hot_val = 5'h00;
    tick(); tick();
    check("rst_addr",  32'(rom_addr),      32'h0);
    check("rst_hit",   32'(pix_hit),       32'h0);
    check("rst_idx",   32'(pix_idx),       32'h0);
    check("rst_valid", 32'(pix_valid_out), 32'h0);
    check("rst_x",     32'(DrawX_out),     32'h0);
    Reset_n = 1'b1;

    // Origin and far corner of tile 0, then latency/alignment of outputs
    set_spr(0, 100, 50, 0, 1'b0, 1'b1); frame();
    pixel(100, 50); tick();
    check("org_addr", 32'(rom_addr), 32'h0000);
    pixel(131, 81); tick();
    check("corner_addr", 32'(rom_addr), 32'h1F1F);
    pixel(132, 81); tick();
    check("miss_hold", 32'(rom_addr),      32'h1F1F);
    check("lat_hitA",  32'(pix_hit),       32'h1);
    check("lat_idxA",  32'(pix_idx),       32'h15);
    check("lat_xA",    32'(DrawX_out),     32'd100);
    check("lat_yA",    32'(DrawY_out),     32'd50);
    check("lat_vA",    32'(pix_valid_out), 32'h1);
    pix_valid = 1'b0; tick();
    check("lat_hitB",  32'(pix_hit),       32'h1);
    check("lat_idxB",  32'(pix_idx),       32'h0A);
    check("lat_xB",    32'(DrawX_out),     32'd131);
    check("lat_yB",    32'(DrawY_out),     32'd81);
    tick();
    check("miss_hit",  32'(pix_hit),       32'h0);
    check("miss_idx",  32'(pix_idx),       32'h0);
    check("miss_v",    32'(pix_valid_out), 32'h1);
    check("miss_x",    32'(DrawX_out),     32'd132);
    tick();
    check("idle_v",    32'(pix_valid_out), 32'h0);

    // Tile base and horizontal flip
    set_spr(0, 100, 50, 9, 1'b0, 1'b1); frame();
    pixel(100, 50); tick();
    check("tile9", 32'(rom_addr), 32'h2020);
    pixel(131, 50); tick();
    check("tile9_r", 32'(rom_addr), 32'h203F);
    set_spr(0, 100, 50, 9, 1'b1, 1'b1); frame();
    pixel(131, 50); tick();
    check("flip_r", 32'(rom_addr), 32'h2020);
    pixel(100, 50); tick();
    check("flip_l", 32'(rom_addr), 32'h203F);

    // Priority between overlapping sprites
    set_spr(0, 200, 200, 0, 1'b0, 1'b1);
    set_spr(1, 200, 200, 1, 1'b0, 1'b1); frame();
    pixel(200, 200); tick();
    check("prio0", 32'(rom_addr), 32'h0000);
    set_spr(0, 200, 200, 0, 1'b0, 1'b0); frame();
    pixel(200, 200); tick();
    check("prio1", 32'(rom_addr), 32'h0020);

    // Transparent winner over opaque sprite 1: no fall-through
    set_spr(0, 200, 200, 2, 1'b0, 1'b1);
    hot_addr = 16'h0040; hot_val = 5'h00; frame();
    pixel(200, 200); tick();
    check("tr_addr", 32'(rom_addr), 32'h0040);
    pix_valid = 1'b0; tick(); tick();
    check("tr_hit", 32'(pix_hit),       32'h0);
    check("tr_idx", 32'(pix_idx),       32'h0);
    check("tr_v",   32'(pix_valid_out), 32'h1);
    check("tr_x",   32'(DrawX_out),     32'd200);
    hot_addr = 16'h144A; hot_val = 5'h07;
    pixel(210, 220); tick();
    check("op_addr", 32'(rom_addr), 32'h144A);
    pix_valid = 1'b0; tick(); tick();
    check("op_hit", 32'(pix_hit),   32'h1);
    check("op_idx", 32'(pix_idx),   32'h07);
    check("op_x",   32'(DrawX_out), 32'd210);
    check("op_y",   32'(DrawY_out), 32'd220);

    // Shadow timing
    set_spr(1, 200, 200, 1, 1'b0, 1'b0);
    set_spr(0, 300, 100, 0, 1'b0, 1'b1); frame();
    spr_x[0] = 10'd400;
    pixel(300, 101); tick();
    check("sh_nofs", 32'(rom_addr), 32'h0100);
    frame_start = 1'b1;
    pixel(301, 101); tick();
    frame_start = 1'b0;
    check("sh_same", 32'(rom_addr), 32'h0101);
    pixel(405, 101); tick();
    check("sh_next", 32'(rom_addr), 32'h0105);

    // Reset mid-line with hits in flight
    tick(); tick();
    check("pre_hit", 32'(pix_hit),   32'h1);
    check("pre_idx", 32'(pix_idx),   32'h10);
    check("pre_x",   32'(DrawX_out), 32'd405);
    Reset_n = 1'b0; tick();
    check("mr_addr", 32'(rom_addr),      32'h0);
    check("mr_hit",  32'(pix_hit),       32'h0);
    check("mr_idx",  32'(pix_idx),       32'h0);
    check("mr_v",    32'(pix_valid_out), 32'h0);
    check("mr_x",    32'(DrawX_out),     32'h0);
    check("mr_y",    32'(DrawY_out),     32'h0);
    Reset_n = 1'b1; tick();
    check("rel1_v",    32'(pix_valid_out), 32'h0);
    check("rel1_addr", 32'(rom_addr),      32'h0);
    tick();
    check("rel2_v", 32'(pix_valid_out), 32'h0);
    tick();
    check("rel3_v",    32'(pix_valid_out), 32'h1);
    check("rel3_hit",  32'(pix_hit),       32'h0);
    check("rel3_addr", 32'(rom_addr),      32'h0);
    frame();
    pixel(405, 101); tick();
    check("rel_fs", 32'(rom_addr), 32'h0105);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Pixel-rate sprite address generator and compositor front-end, feeding the 256x256 sprite-sheet ROM (16-bit address, 5-bit palette index, 1-cycle registered read) and consuming its output.
- Takes DrawX/DrawY from the VGA controller and per-tank sprite attributes from game logic.
- Produces the ROM address, then a latency-aligned palette index with a hit flag for the colour mapper.
- Sprite attributes are double-buffered and updated only at frame boundaries to prevent tearing.

Parameters:
- NUM_SPR, 4, number of sprites; index 0 has highest priority.
- SPR_W, 32, sprite width and height in pixels (square tiles).
- SHEET_W, 256, sheet width in pixels; gives SHEET_W/SPR_W tiles per row.
- COORD_W, 10, screen coordinate width.
- TRANSP_IDX, 5'h00, palette index treated as transparent.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  synchronous reset, active-low.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- spr_x  in  [NUM_SPR][COORD_W]  sprite left edge, unsigned.
- spr_y  in  [NUM_SPR][COORD_W]  sprite top edge, unsigned.
- spr_tile  in  [NUM_SPR][6]  tile number; {row[5:3], col[2:0]}.
- spr_flip  in  [NUM_SPR]  mirror horizontally.
- spr_en  in  [NUM_SPR]  sprite visible.
- DrawX  in  COORD_W  current pixel x.
- DrawY  in  COORD_W  current pixel y.
- pix_valid  in  1  DrawX/DrawY are in the active region.
- rom_addr  out  16  registered address to the sprite ROM.
- rom_data  in  5  ROM output, valid one cycle after rom_addr.
- pix_idx  out  5  palette index of the winning sprite.
- pix_hit  out  1  an opaque sprite pixel is present.
- pix_valid_out  out  1  pix_valid delayed 3 cycles.
- DrawX_out  out  COORD_W  DrawX delayed 3 cycles.
- DrawY_out  out  COORD_W  DrawY delayed 3 cycles.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - Clears all outputs, pipeline registers and shadow attributes to 0, so all sprites are disabled.
  - Outputs stay 0 for 3 cycles after release.
- Shadow attributes:
  - On any cycle with frame_start=1, all spr_* inputs are copied into shadow registers.
  - Pixel lookups use only the shadow copy.
  - A pixel presented in the same cycle as frame_start uses the old shadow values; the new values apply from the next cycle.
- Stage 0 (cycle t, combinational on the inputs against shadow):
  - dx = DrawX - x and dy = DrawY - y, computed at COORD_W+1 bits.
  - Sprite i hits when en=1, dx in [0, SPR_W-1] and dy in [0, SPR_W-1]. A negative result (top bit set) is a miss.
  - The winner is the lowest-index hitting sprite.
  - lx = flip ? SPR_W-1-dx : dx; ly = dy.
  - rom_addr = ((tile_row*SPR_W + ly) * SHEET_W) + tile_col*SPR_W + lx, truncated to 16 bits.
  - Registered at t+1 along with hit_s1, valid_s1, X_s1 and Y_s1.
  - When there is no hit or pix_valid=0, rom_addr holds its previous value and hit_s1=0.
- Stage 1 (t+2): the ROM returns rom_data; hit/valid/X/Y are delayed one more stage to stay aligned.
- Stage 2 (registered, visible at t+3):
  - pix_hit = hit_s2 & (rom_data != TRANSP_IDX).
  - pix_idx = pix_hit ? rom_data : 0.
  - DrawX_out, DrawY_out and pix_valid_out are the aligned copies.
- Transparency: no fall-through. If the winning sprite's pixel is transparent, pix_hit=0 even when a lower-priority sprite overlaps.
- Clipping: sprites crossing the right or bottom screen edge are clipped naturally. Negative positions are unsupported.
- Throughput: one pixel per clock with no stalls. Latency from DrawX/DrawY to pix_* is exactly 3 cycles.
- Reset mid-frame flushes the pipeline; no partial pixel is emitted afterwards.

Decomposition:
- sprite_pkg holds:
  - constants SPR_W, SHEET_W, COORD_W, TRANSP_IDX, ROM_LAT=1;
  - typedef sprite_attr_t struct {x, y, tile[5:0], flip, en};
  - a function tile_base(tile) returning the 16-bit sheet offset.
- Sub-module sprite_hit:
  - per-sprite compare and local-coordinate generation;
  - instantiated NUM_SPR times;
  - the priority mux stays in sprite_fetch.

Test Plan:
- Origin address: sprite0 at (100,50), tile 0, en=1, loaded via frame_start; DrawX=100, DrawY=50 -> rom_addr=0x0000 at t+1. At DrawX=131, DrawY=81 -> 0x1F1F.
- Tile base and flip: tile 9, at (100,50) -> rom_addr=0x2020. Same sprite with flip=1 at DrawX=100 -> 0x203F.
- Priority: sprites 0 (tile 0) and 1 (tile 1) both at (200,200); DrawX=DrawY=200 -> rom_addr=0x0000. Disable sprite 0 -> 0x0020.
- Transparency and latency: ROM model returns 5'h00 at the hit address -> pix_hit=0 at t+3. Returns 5'h07 -> pix_hit=1, pix_idx=7, DrawX_out=DrawX from t.
- Shadow timing: change spr_x without frame_start -> no effect. Pulse frame_start while scanning -> that cycle uses the old position, the next cycle the new one.
- Reset: assert Reset_n=0 mid-line with hits in flight -> all outputs 0 the next cycle; pix_valid_out=0 for 3 cycles after release; sprites disabled until the next frame_start.
